// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, completion
// status codes, RV32I funct3 encodings and request legality helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } lsu_err_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load) return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    return f3 inside {F3_SB, F3_SH, F3_SW};
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Memory-side bus of the load/store unit: request handshake plus response.
interface lsu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store data replication and
// load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rsp_data,
  output logic [3:0]  be,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    be         = 4'b0000;
    store_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << addr_lo;
        store_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << addr_lo;
        store_data = {2{wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign lane_byte = rsp_data[{addr_lo, 3'b000} +: 8];
  assign lane_half = rsp_data[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LW:   load_data = rsp_data;
      F3_LBU:  load_data = {24'h0, lane_byte};
      F3_LHU:  load_data = {16'h0, lane_half};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: captures one core request, performs a single memory
// transaction with timeout, and reports completion, status and load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  lsu_if.master       mem
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  lsu_state_e    state_q, state_d;
  lsu_err_e      err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          is_load_q, is_load_d;
  logic [3:0]    be;
  logic [31:0]   store_data;
  logic [31:0]   load_data;
  logic          in_req;

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rsp_data   (mem.mem_rsp_data),
    .be         (be),
    .store_data (store_data),
    .load_data  (load_data)
  );

  // Progress (handshake or response) wins over timeout in the same cycle
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    funct3_d  = funct3_q;
    is_load_d = is_load_q;
    case (state_q)
      S_IDLE: begin
        if (start && (is_load || is_store)) begin
          if ((is_load && is_store) || !f3_legal(is_load, funct3)) begin
            err_d   = ERR_ILLEGAL;
            state_d = S_DONE;
          end else if (misaligned(funct3, addr[1:0])) begin
            err_d   = ERR_MISALIGN;
            state_d = S_DONE;
          end else begin
            err_d     = ERR_OK;
            addr_d    = addr;
            wdata_d   = wdata;
            funct3_d  = funct3;
            is_load_d = is_load;
            cnt_d     = '0;
            state_d   = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem.mem_req_ready) begin
          state_d = is_load_q ? S_WAIT : S_DONE;
        end else if (cnt_q >= LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem.mem_rsp_valid) begin
          rdata_d = load_data;
          state_d = S_DONE;
        end else if (cnt_q >= LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      err_q     <= ERR_OK;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      funct3_q  <= '0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      funct3_q  <= funct3_d;
      is_load_q <= is_load_d;
    end
  end

  assign in_req = (state_q == S_REQ);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
  assign rdata  = rdata_q;

  // Bus outputs are forced to zero outside REQ so reset leaves them quiet
  assign mem.mem_req_valid = in_req;
  assign mem.mem_we        = in_req & ~is_load_q;
  assign mem.mem_addr      = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem.mem_be        = in_req ? be : 4'b0000;
  assign mem.mem_wdata     = in_req ? store_data : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// operations compared against a behavioural model of the load/store rules.
module tb_load_store_unit;

  localparam int MW = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  err;

  lsu_if mem_bus ();

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_load  (is_load),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .mem      (mem_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_rdata;

  typedef struct {
    int          lat;
    logic [1:0]  e;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        we;
    int          req_cycles;
    int          dones;
    logic        valid_at_done;
  } obs_t;

  typedef struct {
    int          lat;
    logic [1:0]  e;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    int          req_cycles;
  } exp_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and plays memory: ready after rdly request cycles,
  // response after sdly wait cycles. restart_c re-pulses start at that cycle.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rsp,
                        input int rdly, input int sdly, input int restart_c, output obs_t o);
    int   req_n;
    int   wait_n;
    logic hs;
    logic rsp_given;
    o.lat = -1; o.e = '0; o.rd = '0; o.be = '0; o.maddr = '0; o.mwdata = '0;
    o.we = 1'b0; o.req_cycles = 0; o.dones = 0; o.valid_at_done = 1'b0;
    req_n = 0; wait_n = 0; hs = 1'b0; rsp_given = 1'b0;
    @(negedge clk);
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = (c == restart_c);
      if (start) begin
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0;
      end
      mem_bus.mem_req_ready = 1'b0;
      mem_bus.mem_rsp_valid = 1'b0;
      mem_bus.mem_rsp_data  = $urandom;
      if (done) begin
        o.dones++;
        if (o.lat < 0) begin
          o.lat = c; o.e = err; o.rd = rdata; o.valid_at_done = mem_bus.mem_req_valid;
        end
      end
      if (mem_bus.mem_req_valid) begin
        o.req_cycles++;
        o.be = mem_bus.mem_be; o.maddr = mem_bus.mem_addr;
        o.mwdata = mem_bus.mem_wdata; o.we = mem_bus.mem_we;
        mem_bus.mem_req_ready = (req_n >= rdly);
        req_n++;
        if (mem_bus.mem_req_ready) hs = 1'b1;
      end else if (hs && ld && !rsp_given) begin
        mem_bus.mem_rsp_data  = rsp;
        mem_bus.mem_rsp_valid = (wait_n >= sdly);
        wait_n++;
        if (mem_bus.mem_rsp_valid) rsp_given = 1'b1;
      end
      if (o.lat > 0 && c >= o.lat + 2) break;
    end
    if (o.lat < 0) o.rd = rdata;
    start = 1'b0;
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;
  endtask

  // Reference model: result of one operation from the ISA-level rules
  function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rsp,
                                 input int rdly, input int sdly, input logic [31:0] prev);
    exp_t x;
    int   size;
    int   lane;
    logic legal;
    logic [31:0] v;
    x.lat = -1; x.e = 2'd0; x.rd = prev; x.be = 4'h0; x.maddr = 32'h0;
    x.mwdata = 32'h0; x.req_cycles = 0;
    if (!ld && !st) return x;
    x.lat = 1;
    legal = ld ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    if ((ld && st) || !legal) begin
      x.e = 2'd2;
      return x;
    end
    size = 1 << int'(f3[1:0]);
    lane = int'(a[1:0]);
    if (lane % size != 0) begin
      x.e = 2'd1;
      return x;
    end
    x.be     = 4'(((1 << size) - 1) << lane);
    x.maddr  = a & 32'hFFFF_FFFC;
    x.mwdata = (size == 1) ? wd[7:0] * 32'h0101_0101 :
               (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    if (rdly >= MW) begin
      x.e = 2'd3; x.lat = MW + 1; x.req_cycles = MW;
      return x;
    end
    x.req_cycles = rdly + 1;
    if (st) begin
      x.lat = rdly + 2;
    end else begin
      x.lat = rdly + sdly + 3;
      v = rsp >> (8 * lane);
      case (f3)
        3'd0: begin v = v & 32'hFF; if (v >= 32'h80) v = v | 32'hFFFF_FF00; end
        3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
        3'd4: v = v & 32'hFF;
        3'd5: v = v & 32'hFFFF;
        default: v = rsp;
      endcase
      x.rd = v;
    end
    return x;
  endfunction

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = '0; addr = '0; wdata = '0;
    mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0; mem_bus.mem_rsp_data = '0;
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b want 00", err); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_checks++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", mem_bus.mem_req_valid); end
    n_checks++; if (mem_bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", mem_bus.mem_we); end
    n_checks++; if (mem_bus.mem_be !== 4'h0) begin n_fail++; $display("FAIL reset_be got %b want 0000", mem_bus.mem_be); end
    n_checks++; if (mem_bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_bus.mem_addr); end
    n_checks++; if (mem_bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", mem_bus.mem_wdata); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_rdata = 32'h0;
  endtask

  task automatic test_store_word;
    obs_t o;
    run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, o);
    n_checks++; if (o.lat !== 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", o.lat); end
    n_checks++; if (o.e !== 2'b00) begin n_fail++; $display("FAIL sw_err got %b want 00", o.e); end
    n_checks++; if (o.be !== 4'b1111) begin n_fail++; $display("FAIL sw_be got %b want 1111", o.be); end
    n_checks++; if (o.maddr !== 32'h100) begin n_fail++; $display("FAIL sw_addr got %h want 00000100", o.maddr); end
    n_checks++; if (o.mwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata got %h want deadbeef", o.mwdata); end
    n_checks++; if (o.we !== 1'b1) begin n_fail++; $display("FAIL sw_we got %b want 1", o.we); end
    n_checks++; if (o.dones !== 1) begin n_fail++; $display("FAIL sw_done_count got %0d want 1", o.dones); end
  endtask

  task automatic test_load_byte;
    obs_t o;
    run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 0, o);
    n_checks++; if (o.lat !== 3) begin n_fail++; $display("FAIL lb_latency got %0d want 3", o.lat); end
    n_checks++; if (o.rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata got %h want ffffff80", o.rd); end
    n_checks++; if (o.we !== 1'b0) begin n_fail++; $display("FAIL lb_we got %b want 0", o.we); end
    run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 0, o);
    n_checks++; if (o.rd !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata got %h want 00000080", o.rd); end
    n_checks++; if (o.e !== 2'b00) begin n_fail++; $display("FAIL lbu_err got %b want 00", o.e); end
    model_rdata = 32'h0000_0080;
  endtask

  task automatic test_errors;
    obs_t o;
    run_op(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 0, o);
    n_checks++; if (o.e !== 2'b01) begin n_fail++; $display("FAIL lh_misalign_err got %b want 01", o.e); end
    n_checks++; if (o.req_cycles !== 0) begin n_fail++; $display("FAIL lh_misalign_req got %0d want 0", o.req_cycles); end
    n_checks++; if (o.lat !== 1) begin n_fail++; $display("FAIL lh_misalign_latency got %0d want 1", o.lat); end
    n_checks++; if (o.rd !== model_rdata) begin n_fail++; $display("FAIL lh_misalign_rdata got %h want %h", o.rd, model_rdata); end
    run_op(1'b0, 1'b1, 3'b101, 32'h100, 32'h0, 32'h0, 0, 0, 0, o);
    n_checks++; if (o.e !== 2'b10) begin n_fail++; $display("FAIL st_illegal_err got %b want 10", o.e); end
    n_checks++; if (o.req_cycles !== 0) begin n_fail++; $display("FAIL st_illegal_req got %0d want 0", o.req_cycles); end
  endtask

  task automatic test_timeout;
    obs_t o;
    run_op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 100, 0, 0, o);
    n_checks++; if (o.lat !== MW + 1) begin n_fail++; $display("FAIL timeout_latency got %0d want %0d", o.lat, MW + 1); end
    n_checks++; if (o.e !== 2'b11) begin n_fail++; $display("FAIL timeout_err got %b want 11", o.e); end
    n_checks++; if (o.req_cycles !== MW) begin n_fail++; $display("FAIL timeout_req_cycles got %0d want %0d", o.req_cycles, MW); end
    n_checks++; if (o.valid_at_done !== 1'b0) begin n_fail++; $display("FAIL timeout_valid_drop got %b want 0", o.valid_at_done); end
    n_checks++; if (o.rd !== model_rdata) begin n_fail++; $display("FAIL timeout_rdata got %h want %h", o.rd, model_rdata); end
  endtask

  task automatic test_back_to_back;
    obs_t o;
    run_op(1'b0, 1'b1, 3'b000, 32'h2, 32'h0000_00AB, 32'h0, 0, 0, 1, o);
    n_checks++; if (o.be !== 4'b0100) begin n_fail++; $display("FAIL sb_be got %b want 0100", o.be); end
    n_checks++; if (o.mwdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata got %h want abababab", o.mwdata); end
    n_checks++; if (o.dones !== 1) begin n_fail++; $display("FAIL sb_busy_done_count got %0d want 1", o.dones); end
    n_checks++; if (o.rd !== model_rdata) begin n_fail++; $display("FAIL sb_rdata_kept got %h want %h", o.rd, model_rdata); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sb_idle_after got %b want 0", busy); end
  endtask

  task automatic test_random;
    obs_t o;
    exp_t x;
    logic ld, st;
    logic [2:0] f3;
    logic [31:0] a, wd, rsp;
    int kind, rdly, sdly;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      ld = (kind <= 3) || (kind == 8);
      st = (kind >= 4 && kind <= 8);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; wd = $urandom; rsp = $urandom;
      rdly = $urandom_range(0, 1);
      sdly = $urandom_range(0, 1);
      x = model(ld, st, f3, a, wd, rsp, rdly, sdly, model_rdata);
      run_op(ld, st, f3, a, wd, rsp, rdly, sdly, 0, o);
      n_checks++; if (o.lat !== x.lat) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", i, o.lat, x.lat); end
      n_checks++; if (o.dones !== ((x.lat > 0) ? 1 : 0)) begin n_fail++; $display("FAIL rand%0d_done_count got %0d want %0d", i, o.dones, (x.lat > 0) ? 1 : 0); end
      n_checks++; if (o.rd !== x.rd) begin n_fail++; $display("FAIL rand%0d_rdata got %h want %h", i, o.rd, x.rd); end
      n_checks++; if (o.req_cycles !== x.req_cycles) begin n_fail++; $display("FAIL rand%0d_req_cycles got %0d want %0d", i, o.req_cycles, x.req_cycles); end
      if (x.lat > 0) begin
        n_checks++; if (o.e !== x.e) begin n_fail++; $display("FAIL rand%0d_err got %b want %b", i, o.e, x.e); end
      end
      if (x.req_cycles > 0) begin
        n_checks++; if (o.be !== x.be) begin n_fail++; $display("FAIL rand%0d_be got %b want %b", i, o.be, x.be); end
        n_checks++; if (o.maddr !== x.maddr) begin n_fail++; $display("FAIL rand%0d_addr got %h want %h", i, o.maddr, x.maddr); end
        n_checks++; if (o.we !== st) begin n_fail++; $display("FAIL rand%0d_we got %b want %b", i, o.we, st); end
        if (st) begin
          n_checks++; if (o.mwdata !== x.mwdata) begin n_fail++; $display("FAIL rand%0d_wdata got %h want %h", i, o.mwdata, x.mwdata); end
        end
      end
      model_rdata = x.rd;
    end
  endtask

  task automatic test_reset_in_wait;
    int late_dones;
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
    @(negedge clk);
    start = 1'b0;
    mem_bus.mem_req_ready = 1'b1;
    n_checks++; if (mem_bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rstwait_req_valid got %b want 1", mem_bus.mem_req_valid); end
    @(negedge clk);
    mem_bus.mem_req_ready = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstwait_busy_before got %b want 1", busy); end
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstwait_busy got %b want 0", busy); end
    n_checks++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_valid got %b want 0", mem_bus.mem_req_valid); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rstwait_rdata got %h want 0", rdata); end
    @(negedge clk);
    reset = 1'b0;
    mem_bus.mem_rsp_valid = 1'b1;
    mem_bus.mem_rsp_data  = 32'h1234_5678;
    late_dones = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_bus.mem_rsp_valid = 1'b0;
      if (done !== 1'b0 || busy !== 1'b0) late_dones++;
    end
    n_checks++; if (late_dones !== 0) begin n_fail++; $display("FAIL rstwait_late_rsp got %0d active cycles want 0", late_dones); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rstwait_rdata_after got %h want 0", rdata); end
    model_rdata = 32'h0;
  endtask

  initial begin
    test_reset;
    test_store_word;
    test_load_byte;
    test_errors;
    test_timeout;
    test_back_to_back;
    test_random;
    test_reset_in_wait;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
